// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port between the WB stage and a FIFO-buffered
// long-latency unit, with a starvation guard and a pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pipe_valid_i,
    input  logic [4:0]                 pipe_addr_i,
    input  logic [31:0]                pipe_data_i,
    output logic                       pipe_ready_o,
    input  logic                       mdu_valid_i,
    input  logic [4:0]                 mdu_addr_i,
    input  logic [31:0]                mdu_data_i,
    output logic                       mdu_ready_o,
    input  logic                       mark_valid_i,
    input  logic [4:0]                 mark_addr_i,
    input  logic [4:0]                 rs1_addr_i,
    input  logic [4:0]                 rs2_addr_i,
    output logic                       rs1_busy_o,
    output logic                       rs2_busy_o,
    output logic                       rd_wren_o,
    output logic [4:0]                 rd_addr_o,
    output logic [31:0]                rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] q_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STARVE_MAX+1);

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   busy, busy_nx;
    logic          has, force_mdu, grant_mdu, grant_pipe, push;
    logic [4:0]    g_addr;
    logic [31:0]   g_data;

    always_comb begin
        has         = q_count_o != '0;
        force_mdu   = has && starve_cnt == SW'(STARVE_MAX);
        grant_mdu   = has && (force_mdu || !pipe_valid_i);
        grant_pipe  = pipe_valid_i && !grant_mdu;
        pipe_ready_o = !force_mdu;
        mdu_ready_o = q_count_o != CW'(DEPTH);
        push        = mdu_valid_i && mdu_ready_o;
        g_addr      = grant_mdu ? q_addr[rd_ptr] : pipe_addr_i;
        g_data      = grant_mdu ? q_data[rd_ptr] : pipe_data_i;
        rs1_busy_o  = busy[rs1_addr_i];
        rs2_busy_o  = busy[rs2_addr_i];
    end

    // a mark on the register being retired this cycle wins: a new op is outstanding
    always_comb begin
        busy_nx = busy;
        if (grant_mdu) busy_nx[g_addr] = 1'b0;
        if (mark_valid_i && mark_addr_i != 5'd0) busy_nx[mark_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_addr[wr_ptr] <= mdu_addr_i;
            q_data[wr_ptr] <= mdu_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count_o  <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            rd_wren_o  <= 1'b0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (grant_mdu) rd_ptr <= rd_ptr + AW'(1);
            q_count_o  <= q_count_o + CW'(push) - CW'(grant_mdu);
            starve_cnt <= (grant_pipe && has) ?
                          (starve_cnt == SW'(STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1)) : '0;
            busy       <= busy_nx;
            rd_wren_o  <= (grant_mdu || grant_pipe) && g_addr != 5'd0;
            if (grant_mdu || grant_pipe) begin
                rd_addr_o <= g_addr;
                rd_data_o <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the arbitration rules.
module tb_rf_wb_arbiter;
    localparam int DEPTH  = 4;
    localparam int STARVE = 3;

    logic        clk = 1'b0, rst = 1'b1;
    logic        pipe_valid = 0, mdu_valid = 0, mark_valid = 0;
    logic [4:0]  pipe_addr = 0, mdu_addr = 0, mark_addr = 0, rs1 = 0, rs2 = 0;
    logic [31:0] pipe_data = 0, mdu_data = 0;
    logic        pipe_ready, mdu_ready, rs1_busy, rs2_busy, rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  q_count;

    int          total = 0, bad = 0;
    logic [36:0] q[$];
    bit          busy_m[32];
    int          starve_m = 0;
    logic        e_wren = 0;
    logic [4:0]  e_addr = 0;
    logic [31:0] e_data = 0;
    bit          pushed, granted_mdu;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
        .clk_i(clk), .rst_i(rst),
        .pipe_valid_i(pipe_valid), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data), .pipe_ready_o(pipe_ready),
        .mdu_valid_i(mdu_valid), .mdu_addr_i(mdu_addr), .mdu_data_i(mdu_data), .mdu_ready_o(mdu_ready),
        .mark_valid_i(mark_valid), .mark_addr_i(mark_addr),
        .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
        .rd_wren_o(rd_wren), .rd_addr_o(rd_addr), .rd_data_o(rd_data), .q_count_o(q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 0;
        starve_m = 0;
        e_wren = 0;
        e_addr = 0;
        e_data = 0;
    endtask

    task automatic idle();
        pipe_valid = 0;
        mdu_valid = 0;
        mark_valid = 0;
    endtask

    // called at posedge+1 with inputs set; checks combinational outputs, then registered ones
    task automatic step();
        int n;
        bit frc, mrdy, gm, gp;
        logic [36:0] g;
        #2;
        n = q.size();
        frc = n != 0 && starve_m == STARVE;
        mrdy = n < DEPTH;
        chk("pipe_ready", pipe_ready, frc ? 0 : 1);
        chk("mdu_ready", mdu_ready, mrdy);
        chk("rs1_busy", rs1_busy, rs1 != 0 && busy_m[rs1]);
        chk("rs2_busy", rs2_busy, rs2 != 0 && busy_m[rs2]);
        chk("q_count", q_count, n);
        gm = n != 0 && (frc || !pipe_valid);
        gp = !gm && pipe_valid;
        g = gm ? q[0] : {pipe_addr, pipe_data};
        @(posedge clk);
        #1;
        if (gm) begin
            void'(q.pop_front());
            busy_m[g[36:32]] = 0;
        end
        if (gm || gp) begin
            e_addr = g[36:32];
            e_data = g[31:0];
        end
        e_wren = (gm || gp) && g[36:32] != 0;
        starve_m = (gp && n != 0) ? (starve_m < STARVE ? starve_m + 1 : STARVE) : 0;
        pushed = mdu_valid && mrdy;
        granted_mdu = gm;
        if (pushed) q.push_back({mdu_addr, mdu_data});
        if (mark_valid && mark_addr != 0) busy_m[mark_addr] = 1;
        chk("rd_wren", rd_wren, e_wren);
        chk("rd_addr", rd_addr, e_addr);
        chk("rd_data", rd_data, e_data);
        chk("q_count_post", q_count, q.size());
    endtask

    task automatic push_one(input logic [4:0] a, input logic [31:0] d);
        int k;
        mdu_valid = 1;
        mdu_addr = a;
        mdu_data = d;
        for (k = 0; k < 20; k++) begin
            step();
            if (pushed) break;
        end
        if (k == 20) begin
            total++;
            bad++;
            $error("FAIL push_timeout observed=stuck expected=accepted");
        end
        mdu_valid = 0;
    endtask

    initial begin
        int pipe_grants;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_wren", rd_wren, 0);
        chk("reset_count", q_count, 0);
        chk("reset_mdu_ready", mdu_ready, 1);
        chk("reset_pipe_ready", pipe_ready, 1);
        rst = 0;

        // pipe only
        pipe_valid = 1; pipe_addr = 3; pipe_data = 32'h11;
        step();
        chk("pipe_only_addr", rd_addr, 3);
        chk("pipe_only_data", rd_data, 32'h11);
        idle(); step();

        // starvation guard
        pipe_valid = 1; pipe_addr = 1; pipe_data = 32'h100;
        mdu_valid = 1; mdu_addr = 7; mdu_data = 32'hAA;
        step();
        mdu_valid = 0;
        pipe_grants = 0;
        for (int k = 0; k < 3; k++) begin
            pipe_data++;
            step();
            if (!granted_mdu) pipe_grants++;
        end
        chk("starve_pipe_grants", pipe_grants, 3);
        pipe_data++;
        step();
        chk("starve_forced_addr", rd_addr, 7);
        chk("starve_forced_data", rd_data, 32'hAA);
        pipe_data++;
        step();
        chk("starve_resume_addr", rd_addr, 1);
        idle(); step();

        // FIFO full then wrap
        pipe_valid = 1; pipe_addr = 2;
        for (int k = 0; k < 4; k++) push_one(5'(10 + k), 32'hF000 + k);
        pipe_valid = 0;
        for (int k = 4; k < 10; k++) push_one(5'(10 + k), 32'hF000 + k);
        for (int k = 0; k < 6; k++) step();
        chk("full_drained", q_count, 0);

        // scoreboard, including re-mark on the grant cycle
        rs1 = 9; rs2 = 4;
        mark_valid = 1; mark_addr = 9; step();
        mark_valid = 0; step(); step();
        chk("x9_busy", rs1_busy, 1);
        push_one(9, 32'h99);
        step();
        chk("x9_cleared", rs1_busy, 0);
        mark_valid = 1; mark_addr = 9; step();
        mark_valid = 0; push_one(9, 32'h98);
        mark_valid = 1; mark_addr = 9; step();
        mark_valid = 0; step();
        chk("x9_rebusy", rs1_busy, 1);

        // x0 handling
        rs1 = 0;
        mark_valid = 1; mark_addr = 0; step();
        mark_valid = 0;
        push_one(0, 32'hDEAD);
        pipe_valid = 1; pipe_addr = 0; pipe_data = 32'hBEEF; step();
        chk("x0_no_write", rd_wren, 0);
        chk("x0_not_busy", rs1_busy, 0);
        idle(); step();

        // reset mid-operation: 3 entries queued, x5/x6 busy
        rs1 = 5; rs2 = 6;
        mark_valid = 1; mark_addr = 5; step();
        mark_addr = 6; step();
        mark_valid = 0;
        pipe_valid = 1; pipe_addr = 1;
        for (int k = 0; k < 3; k++) push_one(5'(20 + k), 32'hC000 + k);
        chk("pre_reset_count", q_count, 3);
        idle();
        rst = 1;
        #1;
        chk("midrst_count", q_count, 0);
        chk("midrst_busy1", rs1_busy, 0);
        chk("midrst_busy2", rs2_busy, 0);
        chk("midrst_wren", rd_wren, 0);
        #1 rst = 0;
        model_reset();
        for (int k = 0; k < 5; k++) step();

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            pipe_valid = 1'($urandom_range(0, 1));
            pipe_addr = 5'($urandom_range(0, 12));
            pipe_data = $urandom;
            mdu_valid = 1'($urandom_range(0, 1));
            mdu_addr = 5'($urandom_range(0, 12));
            mdu_data = $urandom;
            mark_valid = 1'($urandom_range(0, 3) == 0);
            mark_addr = 5'($urandom_range(0, 12));
            rs1 = 5'($urandom_range(0, 12));
            rs2 = 5'($urandom_range(0, 12));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
